// File: rtl/sort_datapath.sv
// sort_datapath
//   Datapath slave of the in-place exchange-sort engine. Holds the K-entry
//   data memory, the outer (i) and inner (j) index counters and the A/B
//   operand registers, executes the controller strobes and returns the
//   AgtB / zi / zj status flags. A host port reaches the memory while the
//   sort engine is idle.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   Wr                       mem[addr] <= wdata
//   Li/Ei, Lj/Ej             counter i / j load and enable
//   EA, EB                   A / B <= mem[addr]
//   Bout                     write-data select (1 = B, 0 = A)
//   Csel                     address select (1 = j, 0 = i)
//   AgtB, zi, zj             status flags, combinational from registers
//   ext_sel                  host owns the memory; Wr/EA/EB ignored
//   ext_we/addr/wdata/rdata  host write strobe, address, data in/out
module sort_datapath #(
  parameter  int K  = 8,
  parameter  int W  = 8,
  localparam int IW = $clog2(K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Wr,
  input  logic          Li,
  input  logic          Ei,
  input  logic          Lj,
  input  logic          Ej,
  input  logic          EA,
  input  logic          EB,
  input  logic          Bout,
  input  logic          Csel,
  output logic          AgtB,
  output logic          zi,
  output logic          zj,
  input  logic          ext_sel,
  input  logic          ext_we,
  input  logic [IW-1:0] ext_addr,
  input  logic [W-1:0]  ext_wdata,
  output logic [W-1:0]  ext_rdata
);

  // One extra bit so K itself is representable when K is a power of two.
  localparam logic [IW:0]   K_LIM  = K[IW:0];
  localparam int            ZI_INT = K - 2;
  localparam int            ZJ_INT = K - 1;
  localparam logic [IW-1:0] ZI_VAL = ZI_INT[IW-1:0];
  localparam logic [IW-1:0] ZJ_VAL = ZJ_INT[IW-1:0];
  localparam logic [IW-1:0] ONE    = IW'(1);

  logic [IW-1:0] i_reg;
  logic [IW-1:0] j_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  mem [K];

  logic [IW-1:0] addr;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata;
  logic          addr_ok;
  logic          ext_addr_ok;

  logic          mem_we;
  logic [IW-1:0] mem_waddr;
  logic [W-1:0]  mem_wdata;

  assign addr        = Csel ? j_reg : i_reg;
  assign wdata       = Bout ? b_reg : a_reg;
  assign addr_ok     = {1'b0, addr} < K_LIM;
  assign ext_addr_ok = {1'b0, ext_addr} < K_LIM;

  // Indices past the last entry (wrapped counters, non-power-of-2 K) read 0.
  assign rdata     = addr_ok ? mem[addr] : '0;
  assign ext_rdata = ext_addr_ok ? mem[ext_addr] : '0;

  // Single write port, owned either by the host or by the sort strobes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = wdata;
    if (ext_sel) begin
      mem_we    = ext_we && ext_addr_ok;
      mem_waddr = ext_addr;
      mem_wdata = ext_wdata;
    end else begin
      mem_we    = Wr && addr_ok;
    end
  end

  // Memory entries have no reset value. rst is in the sensitivity list only
  // so that a write coinciding with a reset edge is dropped, leaving the
  // partially sorted array intact.
  for (genvar gi = 0; gi < K; gi++) begin : g_mem
    always_ff @(posedge clk or posedge rst) begin
      if (!rst && mem_we && (mem_waddr == IW'(gi))) begin
        mem[gi] <= mem_wdata;
      end
    end
  end

  // Counters and operand registers. A/B sample rdata, which is the pre-write
  // memory content when a write hits the same address in this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_reg <= '0;
      j_reg <= '0;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      if (Ei) begin
        i_reg <= Li ? '0 : i_reg + ONE;
      end
      // j's load uses the pre-edge value of i even when i also steps.
      if (Ej) begin
        j_reg <= Lj ? i_reg + ONE : j_reg + ONE;
      end
      if (!ext_sel && EA) begin
        a_reg <= rdata;
      end
      if (!ext_sel && EB) begin
        b_reg <= rdata;
      end
    end
  end

  assign AgtB = a_reg > b_reg;
  assign zi   = i_reg == ZI_VAL;
  assign zj   = j_reg == ZJ_VAL;

endmodule

// File: tb/tb_sort_datapath.sv
// tb_sort_datapath
//   Directed bench for sort_datapath (K=8, W=8). Steps run in order: reset,
//   host load/unload, asynchronous reset mid-sort, counters, compare/swap,
//   read-during-write, then three full sorts driven by a small controller
//   sequence built from the datapath flags.
module tb_sort_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Wr = 1'b0, Li = 1'b0, Ei = 1'b0, Lj = 1'b0, Ej = 1'b0;
  logic       EA = 1'b0, EB = 1'b0, Bout = 1'b0, Csel = 1'b0;
  logic       AgtB, zi, zj;
  logic       ext_sel = 1'b0, ext_we = 1'b0;
  logic [2:0] ext_addr = 3'd0;
  logic [7:0] ext_wdata = 8'd0;
  logic [7:0] ext_rdata;

  int passed = 0;
  int total  = 0;

  sort_datapath #(.K(8), .W(8)) dut (
    .clk(clk), .rst(rst), .Wr(Wr), .Li(Li), .Ei(Ei), .Lj(Lj), .Ej(Ej),
    .EA(EA), .EB(EB), .Bout(Bout), .Csel(Csel),
    .AgtB(AgtB), .zi(zi), .zj(zj),
    .ext_sel(ext_sel), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_rdata(ext_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("[%0t] %s observed=%0h expected=%0h ok", $time, tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge; strobes are single-cycle pulses and drop afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
    Wr = 1'b0; Li = 1'b0; Ei = 1'b0; Lj = 1'b0; Ej = 1'b0;
    EA = 1'b0; EB = 1'b0; Bout = 1'b0; Csel = 1'b0; ext_we = 1'b0;
  endtask

  task automatic ext_write(input logic [2:0] a, input logic [7:0] d);
    ext_sel = 1'b1; ext_addr = a; ext_wdata = d; ext_we = 1'b1;
    tick();
  endtask

  task automatic ext_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
    ext_addr = a;
    @(negedge clk);
    check(tag, {24'd0, ext_rdata}, {24'd0, exp});
  endtask

  // Byte k of the vector is the value for address k.
  task automatic load_array(input logic [63:0] v);
    for (int k = 0; k < 8; k++) ext_write(3'(k), v[8*k +: 8]);
  endtask

  task automatic check_array(input string tag, input logic [63:0] v);
    for (int k = 0; k < 8; k++) ext_check($sformatf("%s[%0d]", tag, k), 3'(k), v[8*k +: 8]);
  endtask

  // Controller step sequence: init, outer step, inner read, compare,
  // optional swap, reload. Bounded by a step budget.
  task automatic run_sort(output int writes);
    int  steps;
    bit  done;
    bit  inner_done;
    writes = 0; steps = 0; done = 1'b0;
    ext_sel = 1'b0;
    Li = 1'b1; Ei = 1'b1; tick();
    while (!done && steps < 200) begin
      Csel = 1'b0; EA = 1'b1; Lj = 1'b1; Ej = 1'b1; tick();
      inner_done = 1'b0;
      while (!inner_done && steps < 200) begin
        steps++;
        Csel = 1'b1; EB = 1'b1; tick();
        if (AgtB) begin
          Wr = 1'b1; Bout = 1'b1; Csel = 1'b0; tick();
          Wr = 1'b1; Csel = 1'b1; tick();
          writes += 2;
        end
        if (!zj) begin
          Csel = 1'b0; EA = 1'b1; Ej = 1'b1; tick();
        end else begin
          inner_done = 1'b1;
          if (zi) done = 1'b1;
          else begin
            Ei = 1'b1; tick();
          end
        end
      end
    end
    check("sort_done_within_budget", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int wr_count;

    // Power-on reset
    #12;
    check("por_i", {29'd0, dut.i_reg}, 32'd0);
    check("por_a", {24'd0, dut.a_reg}, 32'd0);
    check("por_agtb", {31'd0, AgtB}, 32'd0);
    check("por_zi", {31'd0, zi}, 32'd0);
    check("por_zj", {31'd0, zj}, 32'd0);
    rst = 1'b0;
    tick();

    // Host load/unload; sort strobes must be ignored while host owns memory
    load_array(64'h0406020701080305);
    ext_sel = 1'b1; Wr = 1'b1; EA = 1'b1; Csel = 1'b0; tick();
    check("ext_sel_blocks_ea", {24'd0, dut.a_reg}, 32'd0);
    check_array("ext_load", 64'h0406020701080305);

    // Build up non-zero register state, then reset asynchronously mid-cycle
    ext_sel = 1'b0;
    Ei = 1'b1; tick();                       // i=1
    Ej = 1'b1; tick(); Ej = 1'b1; tick();    // j=2
    EA = 1'b1; Csel = 1'b1; tick();          // A=mem[2]=8
    EB = 1'b1; Csel = 1'b0; tick();          // B=mem[1]=3
    check("pre_rst_agtb", {31'd0, AgtB}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_i", {29'd0, dut.i_reg}, 32'd0);
    check("async_rst_j", {29'd0, dut.j_reg}, 32'd0);
    check("async_rst_a", {24'd0, dut.a_reg}, 32'd0);
    check("async_rst_b", {24'd0, dut.b_reg}, 32'd0);
    check("async_rst_agtb", {31'd0, AgtB}, 32'd0);
    // A write presented across a reset edge must not land (would zero mem[0])
    Wr = 1'b1; Csel = 1'b0; Bout = 1'b0; tick();
    rst = 1'b0;
    check_array("mem_after_rst", 64'h0406020701080305);

    // Counters
    Ei = 1'b1; tick(); Ei = 1'b1; tick();
    Li = 1'b1; tick();
    check("li_alone_holds", {29'd0, dut.i_reg}, 32'd2);
    Li = 1'b1; Ei = 1'b1; tick();
    check("init_i", {29'd0, dut.i_reg}, 32'd0);
    Lj = 1'b1; Ej = 1'b1; tick();
    check("load_j", {29'd0, dut.j_reg}, 32'd1);
    check("zj_low", {31'd0, zj}, 32'd0);
    for (int k = 0; k < 6; k++) begin Ej = 1'b1; tick(); end
    check("j_at_7", {29'd0, dut.j_reg}, 32'd7);
    check("zj_high", {31'd0, zj}, 32'd1);
    for (int k = 0; k < 5; k++) begin Ei = 1'b1; tick(); end
    check("zi_low_at_5", {31'd0, zi}, 32'd0);
    Ei = 1'b1; tick();
    check("i_at_6", {29'd0, dut.i_reg}, 32'd6);
    check("zi_high", {31'd0, zi}, 32'd1);
    Ej = 1'b1; tick();
    check("j_wrap", {29'd0, dut.j_reg}, 32'd0);
    check("zj_after_wrap", {31'd0, zj}, 32'd0);
    Ei = 1'b1; Lj = 1'b1; Ej = 1'b1; tick();   // j <= old i + 1 = 7
    check("j_load_pre_edge_i", {29'd0, dut.j_reg}, 32'd7);
    check("i_step_same_cycle", {29'd0, dut.i_reg}, 32'd7);
    Ei = 1'b1; tick();
    check("i_wrap", {29'd0, dut.i_reg}, 32'd0);

    // Compare and swap on mem[0]=5, mem[1]=3
    ext_sel = 1'b0;
    EA = 1'b1; Csel = 1'b0; tick();
    check("ea_load", {24'd0, dut.a_reg}, 32'd5);
    Lj = 1'b1; Ej = 1'b1; tick();
    EB = 1'b1; Csel = 1'b1; tick();
    check("eb_load", {24'd0, dut.b_reg}, 32'd3);
    check("agtb_set", {31'd0, AgtB}, 32'd1);
    Wr = 1'b1; Bout = 1'b1; Csel = 1'b0; tick();
    ext_check("swap1_mem0", 3'd0, 8'd3);
    Wr = 1'b1; Csel = 1'b1; tick();
    ext_check("swap2_mem1", 3'd1, 8'd5);

    // Equal operands via simultaneous EA/EB
    ext_write(3'd0, 8'd4);
    ext_sel = 1'b0; EA = 1'b1; EB = 1'b1; Csel = 1'b0; tick();
    check("eq_b", {24'd0, dut.b_reg}, 32'd4);
    check("eq_agtb", {31'd0, AgtB}, 32'd0);

    // Read during write: A captures old mem[0], mem[0] takes A's old value
    ext_write(3'd0, 8'd9);
    ext_sel = 1'b0; Wr = 1'b1; EA = 1'b1; Csel = 1'b0; Bout = 1'b0; tick();
    check("rdw_a_old", {24'd0, dut.a_reg}, 32'd9);
    ext_check("rdw_mem_new", 3'd0, 8'd4);

    // Host write strobe is ignored while the sort engine owns the memory
    ext_sel = 1'b0; ext_we = 1'b1; ext_addr = 3'd1; ext_wdata = 8'hAA; tick();
    ext_check("ext_we_ignored", 3'd1, 8'd5);

    // Full sorts
    load_array(64'h0406020701080305);
    run_sort(wr_count);
    check_array("sort_mixed", 64'h0807060504030201);

    load_array(64'h0707070707070707);
    run_sort(wr_count);
    check("sort_equal_no_writes", 32'(wr_count), 32'd0);
    check_array("sort_equal", 64'h0707070707070707);

    load_array(64'h0102030405060708);
    run_sort(wr_count);
    check_array("sort_reverse", 64'h0807060504030201);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
